// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types, window field indices and counter-width helper for the pooling path
//
// Contents:
//   POOL_BIT_REP      default signed pixel width
//   P00..P11          field index of each pixel inside a packed 2x2 window (lsb field = P00)
//   pool_window_t     packed window {p11,p10,p01,p00} at the default pixel width
//   pool_cnt_width()  bit width of a counter covering 0..n-1 (never narrower than 1)
package pool_pkg;

    localparam int POOL_BIT_REP = 8;

    localparam int P00 = 0;
    localparam int P01 = 1;
    localparam int P10 = 2;
    localparam int P11 = 3;

    typedef logic [3:0][POOL_BIT_REP-1:0] pool_window_t;

    function automatic int pool_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_window_buffer_if.sv
// rtl/pool_window_buffer_if.sv - pixel-in / window-out handshake bundle for pool_window_buffer
//
// Signals:
//   in_valid, in_ready, in_data        upstream pixel stream (one signed pixel per beat)
//   out_valid, out_ready, out_data     packed 2x2 window stream {p11,p10,p01,p00}
//   out_last                           qualifies out_data, marks the final window of a frame
// Modports:
//   master  environment side (drives pixels, accepts windows)
//   slave   buffer side
interface pool_window_buffer_if import pool_pkg::*; #(
    parameter int BIT_REP = POOL_BIT_REP
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BIT_REP-1:0]     in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*BIT_REP-1:0]   out_data;
    logic                   out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - one row of pixel pairs for the 2x2 window assembler
//
// Ports:
//   clk    write clock
//   we     write enable
//   waddr  write entry (pair index = column >> 1)
//   wdata  {odd-column pixel, even-column pixel}
//   raddr  read entry
//   rdata  combinational read of entry raddr
// Storage has no reset: every entry is written on an even row before the
// following odd row reads it.
module pool_line_buffer import pool_pkg::*; #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 16,
    parameter int AW    = pool_cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - raster pixel stream to non-overlapping 2x2 window stream (stride 2)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pool_window_buffer_if.slave
//         in_valid/in_ready/in_data      one signed pixel per beat, raster order
//         out_valid/out_ready/out_data   registered window slot {p11,p10,p01,p00}
//         out_last                       set on the last window of each frame
// Even rows pair up pixels into the line buffer; odd rows combine the stored
// pair, the held even-column pixel and the incoming pixel into a window.
module pool_window_buffer import pool_pkg::*; #(
    parameter int BIT_REP = 8,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    pool_window_buffer_if.slave   bus
);
    localparam int CW       = pool_cnt_width(IMG_W);
    localparam int RW       = pool_cnt_width(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = pool_cnt_width(LB_DEPTH);
    localparam int PW       = 2 * BIT_REP;

    if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_w
        $error("pool_window_buffer: IMG_W must be even and >= 2");
    end
    if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_h
        $error("pool_window_buffer: IMG_H must be even and >= 2");
    end

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [BIT_REP-1:0]     hold;
    logic                   out_valid_q;
    logic [4*BIT_REP-1:0]   out_data_q;
    logic                   out_last_q;

    logic                   accept;
    logic                   col_last;
    logic                   row_last;
    logic                   lb_we;
    logic                   win_load;
    logic [LB_AW-1:0]       lb_addr;
    logic [PW-1:0]          lb_rdata;
    logic [4*BIT_REP-1:0]   win_next;

    // A full, stalled output slot freezes the whole pipeline, even rows included.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;

    assign col_last      = (col == CW'(IMG_W - 1));
    assign row_last      = (row == RW'(IMG_H - 1));
    assign lb_addr       = LB_AW'(col >> 1);

    assign lb_we         = accept && !row[0] && col[0];
    assign win_load      = accept &&  row[0] && col[0];

    pool_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (PW),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata ({bus.in_data, hold}),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    // Line-buffer entry is {p01, p00}; the held pixel is p10 and the live pixel p11.
    always_comb begin
        win_next = '0;
        win_next[P00*BIT_REP +: BIT_REP] = lb_rdata[0 +: BIT_REP];
        win_next[P01*BIT_REP +: BIT_REP] = lb_rdata[BIT_REP +: BIT_REP];
        win_next[P10*BIT_REP +: BIT_REP] = hold;
        win_next[P11*BIT_REP +: BIT_REP] = bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            hold <= '0;
        end else if (accept) begin
            if (!col[0]) begin
                hold <= bus.in_data;
            end
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // A transfer empties the slot; a load in the same cycle refills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (win_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_next;
                out_last_q  <= row_last && col_last;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// tb/tb_pool_window_buffer.sv - scoreboard bench for pool_window_buffer (4x4 and 28x28 instances)
module tb_pool_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    pool_window_buffer_if #(.BIT_REP(8)) a_if ();
    pool_window_buffer_if #(.BIT_REP(8)) b_if ();

    pool_window_buffer #(.BIT_REP(8), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if.slave)
    );

    pool_window_buffer #(.BIT_REP(8), .IMG_W(28), .IMG_H(28)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    logic [31:0] obs_a[$];
    int last_cnt_a = 0;
    int win_cnt_b  = 0;
    int ready_mode_a = 0;   // 0: always ready, 1: random, 2: held low
    int frame[784];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: every 2x2 block whose bottom-right pixel has been sent yields one window.
    task automatic push_expected(input int which, input int w, input int h, input int npix);
        logic [32:0] e;
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                int i11;
                i11 = (r + 1) * w + c + 1;
                if (i11 < npix) begin
                    e = {(r == h - 2 && c == w - 2),
                         frame[i11][7:0], frame[i11 - 1][7:0],
                         frame[r * w + c + 1][7:0], frame[r * w + c][7:0]};
                    if (which == 0) exp_a.push_back(e);
                    else            exp_b.push_back(e);
                end
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) frame[i] = int'($urandom_range(0, 255));
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode_a)
            0:       a_if.out_ready = 1'b1;
            1:       a_if.out_ready = 1'($urandom_range(0, 1));
            default: a_if.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_a && a_if.out_valid && a_if.out_ready) begin
            obs_a.push_back(a_if.out_data);
            if (a_if.out_last) last_cnt_a++;
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_window: got %0h, expected no window", a_if.out_data);
            end else begin
                e = exp_a.pop_front();
                check("a_window_data", a_if.out_data, e[31:0]);
                check("a_window_last", a_if.out_last, e[32]);
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_b && b_if.out_valid && b_if.out_ready) begin
            win_cnt_b++;
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_window: got %0h, expected no window", b_if.out_data);
            end else begin
                e = exp_b.pop_front();
                check("b_window_data", b_if.out_data, e[31:0]);
                check("b_window_last", b_if.out_last, e[32]);
            end
        end
    end

    task automatic send_a(input int p, input int gap);
        int n;
        logic acc;
        while (int'($urandom_range(0, 99)) < gap) begin
            a_if.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        a_if.in_valid = 1'b1;
        a_if.in_data  = p[7:0];
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = a_if.in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: got in_ready=0 for %0d cycles, expected accept", n);
        end
    endtask

    task automatic send_b(input int p);
        int n;
        logic acc;
        b_if.in_valid = 1'b1;
        b_if.in_data  = p[7:0];
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = b_if.in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL b_accept_timeout: got in_ready=0 for %0d cycles, expected accept", n);
        end
    endtask

    task automatic send_frame_a(input int gap, input int npix);
        for (int i = 0; i < npix; i++) send_a(frame[i], gap);
        a_if.in_valid = 1'b0;
    endtask

    task automatic drain_a(input string name);
        int n;
        n = 0;
        while (exp_a.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check(name, exp_a.size(), 0);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        int t0;

        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b1;
        ready_mode_a = 2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_out_data",  a_if.out_data, 0);
        check("rst_out_last",  a_if.out_last, 0);
        check("rst_in_ready",  a_if.in_ready, 1);
        check("rst_b_out_valid", b_if.out_valid, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        ready_mode_a = 0;
        a_if.out_ready = 1'b1;

        // Pixels 0..15, continuous, always ready.
        for (int i = 0; i < 16; i++) frame[i] = i;
        obs_a.delete();
        last_cnt_a = 0;
        push_expected(0, 4, 4, 16);
        send_frame_a(0, 16);
        drain_a("seq_drain");
        check("seq_win0", obs_a[0], 32'h05040100);
        check("seq_win3", obs_a[3], 32'h0f0e0b0a);
        check("seq_last_count", last_cnt_a, 1);

        // Signed extremes.
        fill_random(16);
        frame[0] = 8'hFF; frame[1] = 8'h80; frame[2] = 3;   frame[3] = 4;
        frame[4] = 8'h7F; frame[5] = 8'hFE; frame[6] = 0;   frame[7] = 0;
        obs_a.delete();
        push_expected(0, 4, 4, 16);
        send_frame_a(0, 16);
        drain_a("neg_drain");
        check("neg_win0", obs_a[0], 32'hFE7F80FF);

        // Backpressure after the first window.
        fill_random(16);
        push_expected(0, 4, 4, 16);
        ready_mode_a = 2;
        a_if.out_ready = 1'b0;
        fork
            send_frame_a(0, 16);
            begin
                n = 0;
                @(negedge clk);
                while (!a_if.out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_window_seen", a_if.out_valid, 1);
                held = a_if.out_data;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_data_stable", a_if.out_data, held);
                    check("bp_in_ready_low", a_if.in_ready, 0);
                end
                ready_mode_a = 0;
            end
        join
        drain_a("bp_drain");

        // Three back-to-back frames with random gaps and random out_ready.
        ready_mode_a = 1;
        last_cnt_a = 0;
        for (int f = 0; f < 3; f++) begin
            fill_random(16);
            push_expected(0, 4, 4, 16);
            send_frame_a(50, 16);
        end
        drain_a("rand_drain");
        check("rand_last_count", last_cnt_a, 3);

        // Reset after 9 pixels, then a fresh frame.
        ready_mode_a = 0;
        fill_random(16);
        push_expected(0, 4, 4, 9);
        send_frame_a(0, 9);
        drain_a("partial_drain");
        rst_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_out_valid", a_if.out_valid, 0);
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        last_cnt_a = 0;
        fill_random(16);
        push_expected(0, 4, 4, 16);
        send_frame_a(0, 16);
        drain_a("post_rst_drain");
        check("post_rst_last_count", last_cnt_a, 1);

        // Default 28x28 frame, continuous traffic.
        fill_random(784);
        push_expected(1, 28, 28, 784);
        t0 = cyc;
        for (int i = 0; i < 784; i++) send_b(frame[i]);
        b_if.in_valid = 1'b0;
        check("b_frame_cycles", cyc - t0, 784);
        n = 0;
        while (exp_b.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("b_drain", exp_b.size(), 0);
        check("b_window_count", win_cnt_b, 196);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Streaming front end for the 2x2 max-pooling stage.
- Accepts one signed feature-map pixel per beat, in raster order, from the convolution output.
- Buffers one row of pixel pairs and emits each non-overlapping 2x2 window (stride 2) as one packed word to the pooling unit.
- Both sides use valid/ready handshakes; output is a single registered slot.

Parameters:
- BIT_REP, 8, signed pixel width.
- IMG_W, 28, feature-map width in pixels; must be even and >= 2.
- IMG_H, 28, feature-map height in rows; must be even and >= 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_data  in  BIT_REP  signed pixel.
- out_valid  out  1  window word valid.
- out_ready  in  1  pooling unit accepts the window.
- out_data  out  4*BIT_REP  packed window {p11,p10,p01,p00}. p00 occupies bits [BIT_REP-1:0]; p<r><c> is row r, column c within the window.
- out_last  out  1  qualifies out_data; set on the final window of a frame.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_last=0, col=0, row=0, hold register=0. Line-buffer contents are don't-care and are never read before being written. After reset, in_ready=1.
- Handshake:
  - Accept = in_valid & in_ready.
  - in_ready = !out_valid | out_ready. This is combinational from out_ready; no in->out combinational path exists.
  - Output transfer = out_valid & out_ready.
  - out_data and out_last remain stable while out_valid=1 and out_ready=0.
- Counters:
  - col (0..IMG_W-1) advances on each accept.
  - On wrap, col returns to 0 and row (0..IMG_H-1) advances.
  - row wraps to 0 after IMG_H-1, so the next frame starts seamlessly.
- Even row (row[0]=0):
  - Even col: store pixel in hold register.
  - Odd col: write {pixel, hold} into line buffer entry col>>1.
  - No output is produced on even rows.
- Odd row (row[0]=1):
  - Even col: store pixel in hold register.
  - Odd col: read line buffer entry col>>1 to obtain {p01,p00}; p10 = hold register, p11 = in_data.
  - Load out_data, set out_valid=1, set out_last = (row==IMG_H-1 && col==IMG_W-1).
- Latency: window is visible on out_data one cycle after the accept of its p11 pixel.
- out_valid clears on an output transfer unless a new window is loaded in the same cycle. Because in_ready includes out_ready, load and transfer can coincide, sustaining one window per 2 input beats on odd rows.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and no state changes, including on even rows. This conservative rule is accepted.
- Arithmetic: none. Pixels pass unmodified, sign preserved. Counters are $clog2 width; wrap by compare, not by overflow.
- in_valid without in_ready has no effect.
- Mid-operation reset: partial frame discarded; next accepted pixel is treated as (row 0, col 0).
- Windows per frame: (IMG_W/2)*(IMG_H/2).

Decomposition:
- Shared package pool_pkg holds:
  - packed window typedef (4 x signed BIT_REP);
  - localparams for the window field offsets (P00..P11);
  - a helper function for counter width.
- The 2x2 max-pool unit imports the same window typedef.
- One sub-module, pool_line_buffer:
  - IMG_W/2 entries x 2*BIT_REP;
  - one synchronous write port;
  - one combinational read port;
  - no reset on storage.
- Top-level target: counters, hold register, output slot, control; 150-250 lines total.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15 streamed continuously, out_ready=1 -> 4 windows in order:
  - {5,4,1,0}
  - {7,6,3,2}
  - {13,12,9,8}
  - {15,14,11,10}
  - out_last=1 only on the 4th window.
- Negative values: row0 = -1,-128,3,4; row1 = 127,-2,0,0 -> first window {-2,127,-128,-1}, with exact two's-complement bits 8'hFE,8'h7F,8'h80,8'hFF.
- Backpressure: hold out_ready=0 for 5 cycles after window 1 appears -> out_data stable, in_ready=0, no pixel lost. Release -> remaining windows match the golden model.
- Random in_valid gaps (50%) and random out_ready over 3 back-to-back frames -> window sequence equals the scoreboard, and out_last appears once per frame.
- Assert rst after 9 pixels of a frame, then stream a full frame -> out_valid=0 during reset; post-reset windows correspond to the new frame only.
- Default 28x28 frame, continuous traffic -> exactly 196 windows. On odd rows, throughput is one window per 2 accepted pixels.
